// File: rtl/kf8259_in_service_pkg.sv
// kf8259_in_service_pkg: rotate and priority helpers shared by the KF8259 blocks
package KF8259_Common_Package;
  function automatic logic [7:0] rotate_right(input logic [7:0] data, input logic [2:0] n);
    logic [15:0] d;
    d = {data, data} >> n;
    return d[7:0];
  endfunction
  function automatic logic [7:0] rotate_left(input logic [7:0] data, input logic [2:0] n);
    logic [15:0] d;
    d = {data, data} << n;
    return d[15:8];
  endfunction
  // Two's-complement trick isolates the lowest set bit; zero input yields zero.
  function automatic logic [7:0] resolve_priority(input logic [7:0] data);
    return data & (~data + 8'd1);
  endfunction
endpackage

// File: rtl/kf8259_in_service.sv
// kf8259_in_service: in-service register with rotated, masked highest-level search
module kf8259_in_service
  import KF8259_Common_Package::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt_special_mask,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service
);
  logic [2:0] shift;
  logic [7:0] isr_next;
  logic [7:0] highest_next;
  always_comb begin
    shift        = priority_rotate + 3'd1;
    isr_next     = (in_service_register | (latch_in_service ? interrupt : 8'h00)) & ~end_of_interrupt;
    highest_next = rotate_left(resolve_priority(rotate_right(in_service_register & ~interrupt_special_mask, shift)), shift);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_service_register      <= 8'h00;
      highest_level_in_service <= 8'h00;
    end else begin
      in_service_register      <= isr_next;
      highest_level_in_service <= highest_next;
    end
  end
endmodule

// File: tb/tb_kf8259_in_service.sv
// tb_kf8259_in_service: directed vectors with a queue-based scoreboard
module tb_kf8259_in_service;
  logic       clock;
  logic       reset_n;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt_special_mask;
  logic [7:0] interrupt;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;

  typedef struct {
    logic [7:0] isr;
    logic [7:0] hl;
    bit         ci;
    bit         ch;
    string      nm;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  kf8259_in_service dut (
    .clock(clock),
    .reset_n(reset_n),
    .priority_rotate(priority_rotate),
    .interrupt_special_mask(interrupt_special_mask),
    .interrupt(interrupt),
    .latch_in_service(latch_in_service),
    .end_of_interrupt(end_of_interrupt),
    .in_service_register(in_service_register),
    .highest_level_in_service(highest_level_in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: each edge retires one expectation describing the registered outputs.
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.ci) begin
        checks++;
        if (in_service_register !== e.isr) begin
          errors++;
          $display("FAIL %s isr got %02h expected %02h", e.nm, in_service_register, e.isr);
        end
      end
      if (e.ch) begin
        checks++;
        if (highest_level_in_service !== e.hl) begin
          errors++;
          $display("FAIL %s highest got %02h expected %02h", e.nm, highest_level_in_service, e.hl);
        end
      end
    end
  end

  task automatic step(input logic l, input logic [7:0] irq, input logic [7:0] eoi,
                      input logic [7:0] ei, input logic [7:0] eh, input string nm);
    exp_t e;
    latch_in_service = l;
    interrupt        = irq;
    end_of_interrupt = eoi;
    e.isr = ei; e.hl = eh; e.ci = 1'b1; e.ch = 1'b1; e.nm = nm;
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [7:0] m;
    reset_n = 1'b0;
    priority_rotate = 3'd7;
    interrupt_special_mask = 8'h00;
    step(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, "reset");
    reset_n = 1'b1;
    step(1'b1, 8'h01, 8'h00, 8'h01, 8'h00, "t1_latch");
    step(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, "t1_eoi");
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "t1_idle");
    step(1'b1, 8'h04, 8'h00, 8'h04, 8'h00, "t2_latch04");
    step(1'b1, 8'h20, 8'h00, 8'h24, 8'h04, "t2_latch20");
    step(1'b0, 8'h00, 8'h00, 8'h24, 8'h04, "t2_hold");
    step(1'b0, 8'h00, 8'h20, 8'h04, 8'h04, "t2_eoi20");
    step(1'b0, 8'h00, 8'h00, 8'h04, 8'h04, "t2_after");
    step(1'b0, 8'h00, 8'hFF, 8'h00, 8'h04, "t2_clear");
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "t2_empty");
    step(1'b1, 8'h11, 8'h00, 8'h11, 8'h00, "t3_latch");
    step(1'b0, 8'h00, 8'h00, 8'h11, 8'h01, "t3_rot7");
    priority_rotate = 3'd3;
    step(1'b0, 8'h00, 8'h00, 8'h11, 8'h10, "t3_rot3");
    priority_rotate = 3'd7;
    step(1'b0, 8'h00, 8'hFF, 8'h00, 8'h01, "t3_clear");
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "t3_empty");
    interrupt_special_mask = 8'h02;
    step(1'b1, 8'h2A, 8'h00, 8'h2A, 8'h00, "t4_latch");
    step(1'b0, 8'h00, 8'h00, 8'h2A, 8'h08, "t4_mask");
    step(1'b1, 8'hFF, 8'h00, 8'hFF, 8'h08, "t4_all");
    step(1'b0, 8'h00, 8'h00, 8'hFF, 8'h01, "t4_all_hl");
    step(1'b0, 8'h00, 8'hFF, 8'h00, 8'h01, "t4_eoi");
    interrupt_special_mask = 8'h00;
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "t4_empty");
    step(1'b1, 8'h04, 8'h04, 8'h00, 8'h00, "t5_eoi_wins");
    step(1'b1, 8'h55, 8'h00, 8'h55, 8'h00, "t5_latch55");
    step(1'b0, 8'h00, 8'h50, 8'h05, 8'h01, "t5_eoi50");
    step(1'b0, 8'h00, 8'h00, 8'h05, 8'h01, "t5_hold");
    step(1'b1, 8'h50, 8'h00, 8'h55, 8'h01, "t6_fill");
    step(1'b0, 8'h00, 8'h00, 8'h55, 8'h01, "t6_hold");
    reset_n = 1'b0;
    step(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, "t6_reset");
    reset_n = 1'b1;
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "t6_after");
    for (int i = 0; i < 8; i++) begin
      m = 8'(1 << i);
      step(1'b1, m, 8'h00, m, 8'h00, $sformatf("walk_latch%0d", i));
      step(1'b0, 8'h00, m, 8'h00, m, $sformatf("walk_eoi%0d", i));
    end
    latch_in_service = 1'b0;
    end_of_interrupt = 8'h00;
    repeat (2) @(posedge clock);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
